// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scan controller with buffered load and leading-zero blanking
//   clk, rst     : clock, asynchronous active-high reset
//   value, load  : 16-bit value (4 nibbles) offered on load, accepted when ready=1
//   ready        : pending buffer empty
//   lzb_en       : leading-zero blanking enable
//   data         : nibble of the current digit
//   dig          : active-low digit enables
//   blank        : no digit enabled
module seg_scan_ctrl #(
   parameter int SCAN_DIV  = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        load,
   input  logic        lzb_en,
   output logic        ready,
   output logic [3:0]  data,
   output logic [3:0]  dig,
   output logic        blank
);
   localparam int CMAX = SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC;
   localparam int CW   = $clog2(CMAX);
   typedef enum logic {PH_BLANK, PH_SHOW} phase_t;
   phase_t ph, ph_n;
   logic [1:0]    idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [15:0]   disp, disp_n, pend;
   logic          sup, sup_n, last, bnd;
   logic [3:0]    dig_n, data_n;
   always_comb begin
      last   = ph == PH_SHOW ? cnt == CW'(SCAN_DIV - 1) : cnt == CW'(BLANK_CYC - 1);
      ph_n   = !last ? ph : (ph == PH_BLANK ? PH_SHOW : PH_BLANK);
      cnt_n  = last ? '0 : cnt + 1'b1;
      idx_n  = (last && ph == PH_SHOW) ? idx + 2'd1 : idx;
      bnd    = last && ph == PH_SHOW && idx == 2'd3;
      // display buffer only swaps at the frame boundary so a frame never tears
      disp_n = (bnd && !ready) ? pend : disp;
      // suppression is decided once per slot, at SHOW entry
      sup_n  = (ph == PH_BLANK && last) ? (lzb_en && idx != 2'd0 && (disp >> {idx, 2'b00}) == 16'h0) : sup;
      data_n = disp_n[{idx_n, 2'b00} +: 4];
      dig_n  = (ph_n == PH_SHOW && !sup_n) ? ~(4'b0001 << idx_n) : 4'hF;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph    <= PH_BLANK;
         idx   <= '0;
         cnt   <= '0;
         disp  <= '0;
         pend  <= '0;
         sup   <= 1'b0;
         ready <= 1'b1;
         data  <= '0;
         dig   <= 4'hF;
         blank <= 1'b1;
      end else begin
         ph    <= ph_n;
         idx   <= idx_n;
         cnt   <= cnt_n;
         disp  <= disp_n;
         sup   <= sup_n;
         data  <= data_n;
         dig   <= dig_n;
         blank <= dig_n == 4'hF;
         if (load && ready) begin
            pend  <= value;
            ready <= 1'b0;
         end else if (bnd) begin
            ready <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scoreboard bench for seg_scan_ctrl (SCAN_DIV=4, BLANK_CYC=2)
module tb_seg_scan_ctrl;
   localparam int SD = 4, BC = 2, SLOT = SD + BC, FRAME = 4 * SLOT;
   typedef struct {logic [3:0] dig, data; logic blank, ready;} exp_t;
   logic clk = 1'b0, rst = 1'b1, load = 1'b0, lzb_en = 1'b0;
   logic [15:0] value = '0;
   logic ready, blank;
   logic [3:0] data, dig;
   int tests = 0, fails = 0;
   exp_t q[$];
   int t = 0, p, i;
   logic [15:0] mdisp = '0, mpend = '0;
   logic mfull = 1'b0, msup = 1'b0;
   exp_t e, a;

   seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk(clk), .rst(rst), .value(value), .load(load), .lzb_en(lzb_en),
      .ready(ready), .data(data), .dig(dig), .blank(blank));

   always #5 clk = ~clk;

   // reference model: position within the frame is plain cycle arithmetic
   always @(posedge clk) begin
      if (rst) begin
         t = 0; mdisp = '0; mfull = 1'b0; msup = 1'b0;
      end else begin
         p = t % FRAME;
         if (load && !mfull) begin
            mpend = value; mfull = 1'b1;
         end else if (p == FRAME - 1 && mfull) begin
            mdisp = mpend; mfull = 1'b0;
         end
         t++;
         p = t % FRAME;
         i = p / SLOT;
         if (p % SLOT == BC) msup = lzb_en && i != 0 && (mdisp >> (4 * i)) == 16'h0;
         e.dig   = (p % SLOT >= BC && !msup) ? ~(4'b0001 << i) : 4'hF;
         e.blank = e.dig == 4'hF;
         e.data  = 4'(mdisp >> (4 * i));
         e.ready = !mfull;
         q.push_back(e);
      end
   end

   task automatic cmp(input string name, input exp_t x);
      tests++;
      if (dig !== x.dig || data !== x.data || blank !== x.blank || ready !== x.ready) begin
         fails++;
         $display("FAIL %s t=%0d: got dig=%b data=%h blank=%b ready=%b, want dig=%b data=%h blank=%b ready=%b",
                  name, t, dig, data, blank, ready, x.dig, x.data, x.blank, x.ready);
      end
   endtask

   always @(negedge clk) begin
      a = '{dig: 4'hF, data: 4'h0, blank: 1'b1, ready: 1'b1};
      if (rst) cmp("reset", a);
      else if (q.size() > 0) cmp("scan", q.pop_front());
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1; value = v;
      step(1);
      load = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q.delete();
      #1;
      a = '{dig: 4'hF, data: 4'h0, blank: 1'b1, ready: 1'b1};
      cmp("async_reset", a);
      step(2);
      rst = 1'b0;
   endtask

   task automatic wait_pos(input int lo, input int hi, input logic need_full, input string name);
      int n = 0;
      while (!((t % FRAME) >= lo && (t % FRAME) <= hi && mfull == need_full) && n < 200) begin
         step(1);
         n++;
      end
      tests++;
      if (n >= 200) begin
         fails++;
         $display("FAIL %s: timeout at t=%0d, wanted frame pos %0d..%0d full=%b", name, t, lo, hi, need_full);
      end
   endtask

   initial begin
      step(3);
      do_reset();
      step(30);
      wait_pos(8, 8, 1'b0, "mid_frame");
      do_load(16'h1234);
      do_load(16'hFFFF);
      step(60);
      lzb_en = 1'b1;
      wait_pos(3, 20, 1'b0, "lzb_load");
      do_load(16'h0070);
      step(60);
      do_load(16'h0000);
      step(60);
      wait_pos(FRAME - 1, FRAME - 1, 1'b0, "boundary");
      do_load(16'hABCD);
      step(60);
      for (int k = 0; k < 400; k++) begin
         load   = ($urandom_range(0, 7) == 0);
         value  = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         lzb_en = ($urandom_range(0, 9) == 0) ? ~lzb_en : lzb_en;
         step(1);
      end
      load = 1'b0;
      do_load(16'h5678);
      wait_pos(2 * SLOT + BC, 3 * SLOT - 1, 1'b1, "show2_full");
      do_reset();
      step(30);
      step(1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
